mastermind_game_ctrl: RTL and testbench
=======================================

Name: mastermind_game_ctrl

Overview:
- Game controller for the Mastermind board: debounces the push button, captures the secret code, and counts attempts.
- Latches each scored guess and drives the lock output on a win.
- Sits between the guess generator and the combinational scorer: it sources code_o to the scorer and consumes the scorer's match counts.

Parameters:
DEBOUNCE_CYCLES, 65535, consecutive stable synchronized samples required before the debounced button level changes (1..65535)
MAX_ATTEMPTS, 10, scored guesses allowed per game before loss (1..15)
LOCKOUT_CYCLES, 1000000, penalty length after a loss; used only with MASTERMIND_LOCKOUT_EN (1..2^24-1)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
pb_i  input  1  raw asynchronous push button, active-high
guess_i  input  16  current guess, four 4-bit digits {w,x,y,z}
positions_matched_i  input  8  scorer exact-position count for code_o vs guess_i
numbers_matched_i  input  8  scorer wrong-position count for code_o vs guess_i
code_o  output  16  secret code driven to the scorer
positions_o  output  8  latched exact count of the last scored guess
numbers_o  output  8  latched wrong-position count of the last scored guess
score_valid_o  output  1  one-cycle pulse when positions_o/numbers_o update
attempts_o  output  4  scored guesses in the current game
state_o  output  2  SETUP=0, PLAY=1, WON=2, LOST=3
lock_o  output  1  high in WON (unlock actuator)

Behaviour:
- Reset values: code_o=0, positions_o=0, numbers_o=0, score_valid_o=0, attempts_o=0, state_o=SETUP, lock_o=0. The synchronizer flops, debounce counter and debounced level are all 0.
- Synchronizer: two flops on pb_i produce pb_s.
- Debounce counter: clears whenever pb_s equals the debounced level. Otherwise it increments.
- When the counter reaches DEBOUNCE_CYCLES-1 while pb_s still differs, the debounced level flips and the counter clears.
- A bounce shorter than DEBOUNCE_CYCLES produces no change.
- press: registered one-cycle pulse on the 0->1 transition of the debounced level. Release generates nothing. A button held through reset yields one press once debounce completes.
- All FSM actions below occur on the cycle press=1. Results are visible on the next clock edge. State transitions happen only on press.
- SETUP:
  - code_o <= guess_i, attempts_o <= 0, positions_o/numbers_o <= 0.
  - Next state is PLAY.
- PLAY:
  - positions_o <= positions_matched_i, numbers_o <= numbers_matched_i, score_valid_o <= 1 for exactly one cycle.
  - attempts_o <= attempts_o+1.
  - If positions_matched_i == 4, next state is WON. Values >4 are not a win.
  - Else if attempts_o+1 == MAX_ATTEMPTS, next state is LOST.
  - Else stay in PLAY.
  - A win on the final attempt goes to WON, not LOST.
- WON:
  - lock_o=1 (registered, asserted the cycle state_o becomes WON).
  - press -> SETUP and lock_o=0.
  - code_o and the scores are held until the SETUP capture.
- LOST:
  - press -> SETUP.
  - lock_o stays 0.
- code_o is constant throughout PLAY. The scorer inputs are sampled on the press cycle only; guess_i changes at other times are ignored.
- attempts_o never exceeds MAX_ATTEMPTS and never wraps.
- rst at any time, including mid-debounce or in the same cycle as press, forces all reset values. rst has priority over press.

Optional Feature:
MASTERMIND_LOCKOUT_EN
- Defined:
  - Entry to LOST loads a 24-bit penalty counter with LOCKOUT_CYCLES. It decrements every cycle to 0.
  - Presses in LOST are ignored while the counter is nonzero.
  - The debouncer still runs, so a press is accepted only after the counter reaches 0.
  - rst clears the counter.
- Undefined: no counter exists, and the first press in LOST returns to SETUP.

Test Plan:
- Debounce (bench DEBOUNCE_CYCLES=4): pulse pb_i high for 3 cycles, then low -> no press and state_o stays 0. Hold pb_i high for 10 cycles -> exactly one press, state_o goes 0->1, code_o=guess_i.
- Code capture: in SETUP with guess_i=16'h1234, press -> code_o=16'h1234, state_o=1, attempts_o=0. Then change guess_i to 16'h5678 -> code_o stays 16'h1234.
- Scoring: in PLAY, positions_matched_i=2, numbers_matched_i=1, press -> the next cycle shows positions_o=2, numbers_o=1, score_valid_o high for 1 cycle, attempts_o=1, state_o=1.
- Win: positions_matched_i=4 on press -> state_o=2, lock_o=1. Next press -> state_o=0, lock_o=0.
- Loss and last-attempt win (MAX_ATTEMPTS=3):
  - Three presses with positions_matched_i=1 -> state_o=3, attempts_o=3, lock_o=0.
  - Separate game: two misses, then positions_matched_i=4 on the third press -> state_o=2.
- Reset and lockout (MASTERMIND_LOCKOUT_EN defined, LOCKOUT_CYCLES=20):
  - A press in LOST 5 cycles after entry is ignored. A press after 20 cycles -> SETUP.
  - rst asserted mid-PLAY with attempts_o=2 -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/mastermind_game_ctrl.sv
// rtl/mastermind_game_ctrl.sv - Mastermind game controller: button debounce, code capture, attempt counting
// Define MASTERMIND_LOCKOUT_EN to add a penalty window after a loss during which presses are ignored.
module mastermind_game_ctrl #(
  parameter int DEBOUNCE_CYCLES = 65535,
  parameter int MAX_ATTEMPTS    = 10,
  parameter int LOCKOUT_CYCLES  = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pb_i,
  input  logic [15:0] guess_i,
  input  logic [7:0]  positions_matched_i,
  input  logic [7:0]  numbers_matched_i,
  output logic [15:0] code_o,
  output logic [7:0]  positions_o,
  output logic [7:0]  numbers_o,
  output logic        score_valid_o,
  output logic [3:0]  attempts_o,
  output logic [1:0]  state_o,
  output logic        lock_o
);

  typedef enum logic [1:0] {SETUP = 2'd0, PLAY = 2'd1, WON = 2'd2, LOST = 2'd3} state_t;

  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]  ATT_MAX = 4'(MAX_ATTEMPTS);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES out of range");
  end
  if (MAX_ATTEMPTS < 1 || MAX_ATTEMPTS > 15) begin : g_bad_attempts
    $error("MAX_ATTEMPTS out of range");
  end
  if (LOCKOUT_CYCLES < 1 || LOCKOUT_CYCLES > 16777215) begin : g_bad_lockout
    $error("LOCKOUT_CYCLES out of range");
  end

  logic        pb_meta;
  logic        pb_s;
  logic        db_level;
  logic [15:0] db_cnt;
  logic        press;

  // The level only follows pb_s after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      pb_meta  <= 1'b0;
      pb_s     <= 1'b0;
      db_level <= 1'b0;
      db_cnt   <= '0;
      press    <= 1'b0;
    end else begin
      pb_meta <= pb_i;
      pb_s    <= pb_meta;
      press   <= 1'b0;
      if (pb_s == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_level <= pb_s;
        db_cnt   <= '0;
        press    <= pb_s;
      end else begin
        db_cnt <= db_cnt + 16'd1;
      end
    end
  end

  state_t     state;
  state_t     state_next;
  logic       lockout_busy;
  logic [3:0] attempts_inc;
  logic       win;
  logic       capture_code;
  logic       load_score;

  assign attempts_inc = attempts_o + 4'd1;
  assign win          = (positions_matched_i == 8'd4);

`ifdef MASTERMIND_LOCKOUT_EN
  localparam logic [23:0] LOCK_LOAD = 24'(LOCKOUT_CYCLES);
  logic [23:0] lock_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_cnt <= '0;
    end else if (state == PLAY && state_next == LOST) begin
      lock_cnt <= LOCK_LOAD;
    end else if (lock_cnt != '0) begin
      lock_cnt <= lock_cnt - 24'd1;
    end
  end

  assign lockout_busy = (lock_cnt != '0);
`else
  assign lockout_busy = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= SETUP;
    else     state <= state_next;
  end

  // A win on the final attempt takes precedence over the loss.
  always_comb begin
    state_next = state;
    if (press) begin
      case (state)
        SETUP: state_next = PLAY;
        PLAY: begin
          if (win)                           state_next = WON;
          else if (attempts_inc == ATT_MAX)  state_next = LOST;
        end
        WON:   state_next = SETUP;
        LOST:  if (!lockout_busy) state_next = SETUP;
        default: state_next = SETUP;
      endcase
    end
  end

  always_comb begin
    capture_code = press && (state == SETUP);
    load_score   = press && (state == PLAY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      code_o        <= '0;
      positions_o   <= '0;
      numbers_o     <= '0;
      score_valid_o <= 1'b0;
      attempts_o    <= '0;
      lock_o        <= 1'b0;
    end else begin
      score_valid_o <= load_score;
      lock_o        <= (state_next == WON);
      if (capture_code) begin
        code_o      <= guess_i;
        attempts_o  <= '0;
        positions_o <= '0;
        numbers_o   <= '0;
      end
      if (load_score) begin
        positions_o <= positions_matched_i;
        numbers_o   <= numbers_matched_i;
        attempts_o  <= attempts_inc;
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_mastermind_game_ctrl.sv
// tb/tb_mastermind_game_ctrl.sv - randomized bench with a game-rule model for mastermind_game_ctrl
// Lockout expectations follow MASTERMIND_LOCKOUT_EN when it is defined for the build.
module tb_mastermind_game_ctrl;

  localparam int D    = 4;
  localparam int MAXA = 3;
  localparam int LOCK = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pb_i = 1'b0;
  logic [15:0] guess_i = '0;
  logic [7:0]  pm = '0;
  logic [7:0]  nm = '0;
  logic [15:0] code_o;
  logic [7:0]  positions_o;
  logic [7:0]  numbers_o;
  logic        score_valid_o;
  logic [3:0]  attempts_o;
  logic [1:0]  state_o;
  logic        lock_o;

  always #5 clk = ~clk;

  mastermind_game_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .MAX_ATTEMPTS   (MAXA),
    .LOCKOUT_CYCLES (LOCK)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .pb_i               (pb_i),
    .guess_i            (guess_i),
    .positions_matched_i(pm),
    .numbers_matched_i  (nm),
    .code_o             (code_o),
    .positions_o        (positions_o),
    .numbers_o          (numbers_o),
    .score_valid_o      (score_valid_o),
    .attempts_o         (attempts_o),
    .state_o            (state_o),
    .lock_o             (lock_o)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;
  int sv_seen  = 0;

  // Reference: button history and game rules
  bit          m_s1, m_s2, m_level, m_press, m_sv, m_lock;
  int          m_run, m_att, m_state, m_pen;
  logic [15:0] m_code;
  logic [7:0]  m_pos, m_num;

  task automatic model_step();
    bit busy;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_level = 0; m_press = 0; m_run = 0;
      m_code = '0; m_pos = '0; m_num = '0; m_sv = 0; m_att = 0;
      m_state = 0; m_lock = 0; m_pen = 0;
    end else begin
      busy = (m_pen != 0);
      if (m_pen != 0) m_pen--;
      m_sv = 0;
      if (m_press) begin
        case (m_state)
          0: begin m_code = guess_i; m_att = 0; m_pos = '0; m_num = '0; m_state = 1; end
          1: begin
            m_pos = pm; m_num = nm; m_sv = 1; m_att++;
            if (pm == 8'd4) begin
              m_state = 2; m_lock = 1;
            end else if (m_att == MAXA) begin
              m_state = 3;
`ifdef MASTERMIND_LOCKOUT_EN
              m_pen = LOCK;
`endif
            end
          end
          2: begin m_state = 0; m_lock = 0; end
          default: if (!busy) m_state = 0;
        endcase
      end
      // level flips once D consecutive synchronized samples disagree with it
      m_press = 0;
      if (m_s2 != m_level) begin
        m_run++;
        if (m_run == D) begin
          m_level = m_s2; m_run = 0; m_press = m_s2;
        end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = pb_i;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      n_checks++;
      if ({code_o, positions_o, numbers_o, score_valid_o, attempts_o, state_o, lock_o} ===
          {m_code, m_pos, m_num, m_sv, 4'(m_att), 2'(m_state), m_lock})
        n_pass++;
      else
        $display("FAIL cycle_model t=%0t: got code=%h pos=%0d num=%0d sv=%0d att=%0d st=%0d lock=%0d, need code=%h pos=%0d num=%0d sv=%0d att=%0d st=%0d lock=%0d",
                 $time, code_o, positions_o, numbers_o, score_valid_o, attempts_o, state_o, lock_o,
                 m_code, m_pos, m_num, m_sv, m_att, m_state, m_lock);
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, need %0h", name, act, exp);
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_btn(logic [15:0] g, logic [7:0] p, logic [7:0] n);
    guess_i = g; pm = p; nm = n; sv_seen = 0;
    pb_i = 1'b1;
    repeat (D + 4) begin @(negedge clk); if (score_valid_o) sv_seen++; end
    pb_i = 1'b0;
    repeat (D + 4) begin @(negedge clk); if (score_valid_o) sv_seen++; end
  endtask

  task automatic check_reset_values(string tag);
    check({tag, "_code"}, code_o, 0);
    check({tag, "_pos"}, positions_o, 0);
    check({tag, "_num"}, numbers_o, 0);
    check({tag, "_sv"}, score_valid_o, 0);
    check({tag, "_att"}, attempts_o, 0);
    check({tag, "_state"}, state_o, 0);
    check({tag, "_lock"}, lock_o, 0);
  endtask

  initial begin
    rst = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    check_reset_values("reset");
    rst = 1'b0;

    pb_i = 1'b1; idle(3); pb_i = 1'b0; idle(10);
    check("bounce_state", state_o, 0);

    press_btn(16'h1234, 8'd0, 8'd0);
    check("capture_code", code_o, 16'h1234);
    check("capture_state", state_o, 1);
    check("capture_att", attempts_o, 0);
    guess_i = 16'h5678; idle(5);
    check("code_hold", code_o, 16'h1234);

    press_btn(16'h5678, 8'd2, 8'd1);
    check("score_pos", positions_o, 2);
    check("score_num", numbers_o, 1);
    check("score_pulse", sv_seen, 1);
    check("score_att", attempts_o, 1);
    check("score_state", state_o, 1);

    press_btn(16'h1234, 8'd4, 8'd0);
    check("win_state", state_o, 2);
    check("win_lock", lock_o, 1);
    check("win_code_held", code_o, 16'h1234);
    press_btn(16'h0000, 8'd0, 8'd0);
    check("win_exit_state", state_o, 0);
    check("win_exit_lock", lock_o, 0);

    press_btn(16'hABCD, 8'd0, 8'd0);
    press_btn(16'h1111, 8'd5, 8'd0);
    check("five_not_win", state_o, 1);
    press_btn(16'h1111, 8'd1, 8'd0);
    press_btn(16'h1111, 8'd1, 8'd0);
    check("loss_state", state_o, 3);
    check("loss_att", attempts_o, 3);
    check("loss_lock", lock_o, 0);
`ifdef MASTERMIND_LOCKOUT_EN
    press_btn(16'h2222, 8'd0, 8'd0);
    check("lockout_ignored", state_o, 3);
    press_btn(16'h2222, 8'd0, 8'd0);
    check("lockout_release", state_o, 0);
`else
    press_btn(16'h2222, 8'd0, 8'd0);
    check("loss_exit", state_o, 0);
`endif

    press_btn(16'h4321, 8'd0, 8'd0);
    press_btn(16'h4321, 8'd0, 8'd1);
    press_btn(16'h4321, 8'd3, 8'd0);
    press_btn(16'h4321, 8'd4, 8'd0);
    check("last_win_state", state_o, 2);
    check("last_win_att", attempts_o, 3);
    press_btn(16'h0000, 8'd0, 8'd0);
    check("last_win_exit", state_o, 0);

    press_btn(16'h9876, 8'd0, 8'd0);
    press_btn(16'h9876, 8'd1, 8'd2);
    press_btn(16'h9876, 8'd2, 8'd2);
    check("pre_rst_att", attempts_o, 2);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    check_reset_values("mid_rst");

    for (int i = 0; i < 400; i++) begin
      guess_i = 16'($urandom);
      pm      = 8'($urandom_range(0, 5));
      nm      = 8'($urandom_range(0, 4));
      pb_i    = 1'($urandom_range(0, 1));
      rst     = ($urandom_range(0, 60) == 0);
      repeat ($urandom_range(1, 12)) @(negedge clk);
      rst = 1'b0;
    end

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
